// File: rtl/vend_slot_arbiter.sv
// vend_slot_arbiter: round-robin coin-slot arbiter feeding a shared credit engine and soda dispenser.
// Define VEND_DROP_TIMEOUT_EN to abort and refund drops whose drop_ack never arrives.
module vend_slot_arbiter #(
    parameter int NUM_SLOTS    = 4,
    parameter int PRICE        = 4,
    parameter int CREDIT_W     = 4,
    parameter int DROP_TIMEOUT = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SLOTS-1:0]   slot_valid,
    input  logic [2*NUM_SLOTS-1:0] slot_coin,
    output logic [NUM_SLOTS-1:0]   slot_ready,
    output logic [CREDIT_W-1:0]    credit,
    output logic                   drop_req,
    input  logic                   drop_ack,
    output logic [7:0]             drop_count,
    output logic                   bad_coin,
    output logic                   drop_fault
);

    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

    typedef enum logic {IDLE, DROP} state_t;

    state_t              state;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    ptr_next;
    logic                grant_any;
    logic                accept;
    logic [1:0]          grant_coin;
    logic [CREDIT_W-1:0] coin_value;
    int                  scan_idx;

`ifdef VEND_DROP_TIMEOUT_EN
    localparam int TMR_W = $clog2(DROP_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(DROP_TIMEOUT - 1);
    logic [TMR_W-1:0] drop_timer;
`endif

    // Scan upward from the round-robin pointer, wrapping, for the first presenting slot.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= NUM_SLOTS) begin
                scan_idx = scan_idx - NUM_SLOTS;
            end
            if (!grant_any && slot_valid[PTR_W'(scan_idx)]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(scan_idx);
            end
        end
    end

    assign ptr_next   = (grant_idx == LAST_SLOT) ? '0 : grant_idx + 1'b1;
    assign grant_coin = slot_coin[{grant_idx, 1'b0} +: 2];
    assign accept     = (state == IDLE) && (credit < PRICE_C) && grant_any;

    always_comb begin
        case (grant_coin)
            2'b01:   coin_value = CREDIT_W'(1);
            2'b10:   coin_value = CREDIT_W'(3);
            2'b11:   coin_value = CREDIT_W'(5);
            default: coin_value = '0;
        endcase
    end

    always_comb begin
        slot_ready = '0;
        if (accept) begin
            slot_ready[grant_idx] = 1'b1;
        end
    end

    // Coins are only taken below PRICE, so credit tops out at PRICE+4 and cannot wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            credit     <= '0;
            drop_req   <= 1'b0;
            drop_count <= '0;
            bad_coin   <= 1'b0;
`ifdef VEND_DROP_TIMEOUT_EN
            drop_fault <= 1'b0;
            drop_timer <= '0;
`endif
        end else begin
            bad_coin <= 1'b0;
`ifdef VEND_DROP_TIMEOUT_EN
            drop_fault <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (credit >= PRICE_C) begin
                        credit   <= credit - PRICE_C;
                        drop_req <= 1'b1;
                        state    <= DROP;
`ifdef VEND_DROP_TIMEOUT_EN
                        drop_timer <= '0;
`endif
                    end else if (grant_any) begin
                        ptr      <= ptr_next;
                        credit   <= credit + coin_value;
                        bad_coin <= (grant_coin == 2'b00);
                    end
                end
                DROP: begin
                    if (drop_ack) begin
                        drop_count <= drop_count + 8'd1;
                        drop_req   <= 1'b0;
                        state      <= IDLE;
                    end
`ifdef VEND_DROP_TIMEOUT_EN
                    else if (drop_timer == TIMER_LAST) begin
                        credit     <= credit + PRICE_C;
                        drop_fault <= 1'b1;
                        drop_req   <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        drop_timer <= drop_timer + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef VEND_DROP_TIMEOUT_EN
    assign drop_fault = 1'b0;
`endif

endmodule

// File: tb/tb_vend_slot_arbiter.sv
// tb_vend_slot_arbiter: directed and random coin/ack traffic checked against a behavioural credit model.
module tb_vend_slot_arbiter;

    localparam int N     = 4;
    localparam int PRICE = 4;
    localparam int CW    = 4;
    localparam int DT    = 16;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   slot_valid;
    logic [2*N-1:0] slot_coin;
    logic [N-1:0]   slot_ready;
    logic [CW-1:0]  credit;
    logic           drop_req;
    logic           drop_ack;
    logic [7:0]     drop_count;
    logic           bad_coin;
    logic           drop_fault;

    int vectors     = 0;
    int miscompares = 0;

    int m_credit;
    int m_ptr;
    int m_count;
    int m_age;
    bit m_drop;
    bit m_bad;
    bit m_fault;
    int starve[N];

    always #5 clock = ~clock;

    vend_slot_arbiter #(
        .NUM_SLOTS(N), .PRICE(PRICE), .CREDIT_W(CW), .DROP_TIMEOUT(DT)
    ) dut (
        .clock(clock), .reset(reset), .slot_valid(slot_valid), .slot_coin(slot_coin),
        .slot_ready(slot_ready), .credit(credit), .drop_req(drop_req), .drop_ack(drop_ack),
        .drop_count(drop_count), .bad_coin(bad_coin), .drop_fault(drop_fault)
    );

    function automatic int coinValue(input logic [1:0] code);
        case (code)
            2'b01:   return 1;
            2'b10:   return 3;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One clock: drive inputs, check the DUT against the model, then advance the model across the edge.
    task automatic applyStimulus(input bit rst, input logic [N-1:0] v, input logic [2*N-1:0] c, input bit ack);
        int           g;
        logic [N-1:0] exp_ready;
        logic [1:0]   code;
        @(negedge clock);
        reset      = rst;
        slot_valid = v;
        slot_coin  = c;
        drop_ack   = ack;
        #1;
        g = -1;
        if (!m_drop && m_credit < PRICE) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        checkOutput("slot_ready", 32'(slot_ready), 32'(exp_ready));
        checkOutput("credit", 32'(credit), 32'(m_credit));
        checkOutput("drop_req", 32'(drop_req), 32'(m_drop));
        checkOutput("drop_count", 32'(drop_count), 32'(m_count));
        checkOutput("bad_coin", 32'(bad_coin), 32'(m_bad));
        checkOutput("drop_fault", 32'(drop_fault), 32'(m_fault));

        if (!rst && slot_ready != '0) begin
            for (int i = 0; i < N; i++) begin
                if (slot_ready[i] || !v[i]) starve[i] = 0;
                else begin
                    starve[i]++;
                    checkOutput("starvation", 32'(starve[i] >= N), 32'd0);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rst || !v[i]) starve[i] = 0;
        end

        m_bad   = 1'b0;
        m_fault = 1'b0;
        if (rst) begin
            m_credit = 0; m_ptr = 0; m_count = 0; m_drop = 1'b0; m_age = 0;
        end else if (!m_drop) begin
            if (m_credit >= PRICE) begin
                m_credit -= PRICE;
                m_drop = 1'b1;
                m_age  = 0;
            end else if (g >= 0) begin
                code = c[2*g +: 2];
                m_credit += coinValue(code);
                m_ptr = (g + 1) % N;
                m_bad = (code == 2'b00);
            end
        end else if (ack) begin
            m_count = (m_count + 1) % 256;
            m_drop  = 1'b0;
        end else begin
`ifdef VEND_DROP_TIMEOUT_EN
            if (m_age == DT - 1) begin
                m_credit += PRICE;
                m_fault = 1'b1;
                m_drop  = 1'b0;
            end
`endif
            m_age++;
        end
    endtask

    task automatic idleCycles(input int n, input bit ack);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, ack);
    endtask

    initial begin
        reset = 1'b1; slot_valid = '0; slot_coin = '0; drop_ack = 1'b0;
        m_credit = 0; m_ptr = 0; m_count = 0; m_age = 0;
        m_drop = 1'b0; m_bad = 1'b0; m_fault = 1'b0;
        for (int i = 0; i < N; i++) starve[i] = 0;
        repeat (2) @(posedge clock);

        $display("[TB] slot0 circle coins x4, delayed ack");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0001, 8'b0000_0001, 1'b0);
        idleCycles(4, 1'b0);
        idleCycles(1, 1'b1);
        idleCycles(2, 1'b0);

        $display("[TB] slot1 triangle then pentagon, two drops");
        applyStimulus(1'b0, 4'b0010, 8'b0000_1000, 1'b0);
        applyStimulus(1'b0, 4'b0010, 8'b0000_1100, 1'b0);
        idleCycles(3, 1'b0);
        idleCycles(6, 1'b1);

        $display("[TB] all slots valid, immediate ack");
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, 4'b1111, 8'b0101_0101, 1'b1);
        idleCycles(4, 1'b1);

        $display("[TB] slot2 invalid coin then pentagon");
        applyStimulus(1'b0, 4'b0100, 8'b0000_0000, 1'b0);
        applyStimulus(1'b0, 4'b0100, 8'b0011_0000, 1'b0);
        idleCycles(3, 1'b0);
        idleCycles(3, 1'b1);

        $display("[TB] reset during drop handshake");
        for (int i = 0; i < 10 && !m_drop; i++) applyStimulus(1'b0, 4'b0001, 8'b0000_0011, 1'b0);
        idleCycles(2, 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        idleCycles(2, 1'b0);

        $display("[TB] credit reaches PRICE with no ack");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b1000, 8'b0100_0000, 1'b0);
        idleCycles(2 * DT + 8, 1'b0);
        idleCycles(4, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) == 0, N'($urandom), (2*N)'($urandom),
                          $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vend_slot_arbiter.md
Name: vend_slot_arbiter

Overview:
- Shares one soda credit engine and one dispenser among NUM_SLOTS coin slots.
- Round-robin arbitration accepts at most one coin per cycle over per-slot valid/ready handshakes.
- Accumulates credit using the vending coin values (circle=1, triangle=3, pentagon=5), soda price PRICE.
- Sequences each soda drop to the dispenser over a req/ack handshake; sits between the coin-slot front ends and the dispenser.

Parameters:
- NUM_SLOTS, 4, number of coin slots (2..8).
- PRICE, 4, credits per soda (1..10).
- CREDIT_W, 4, credit register width; must satisfy PRICE+4 < 2**CREDIT_W.
- DROP_TIMEOUT, 16, cycles to wait for drop_ack (used only with the optional feature).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- slot_valid, input, NUM_SLOTS, slot i presents a coin.
- slot_coin, input, 2*NUM_SLOTS, coin code of slot i in bits [2i+1:2i]: 00 invalid, 01 circle=1, 10 triangle=3, 11 pentagon=5.
- slot_ready, output, NUM_SLOTS, one-hot grant; the coin is consumed on the cycle slot_valid[i] and slot_ready[i] are both high.
- credit, output, CREDIT_W, current credit after drops deducted.
- drop_req, output, 1, request one soda from the dispenser.
- drop_ack, input, 1, dispenser completion; sampled only while drop_req=1.
- drop_count, output, 8, total sodas dispensed; wraps 255 to 0.
- bad_coin, output, 1, one-cycle pulse when a code-00 coin is consumed.
- drop_fault, output, 1, one-cycle pulse on drop timeout; tied 0 without the macro.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values: state=IDLE, credit=0, drop_req=0, drop_count=0, bad_coin=0, drop_fault=0, RR pointer=0 (slot 0 highest priority).
- slot_ready is combinational from state, credit and slot_valid. All other outputs are registered.
- FSM has two states, IDLE and DROP.
- IDLE with credit >= PRICE:
  - slot_ready=0.
  - credit <= credit-PRICE, go to DROP. drop_req is high the next cycle.
- IDLE with credit < PRICE:
  - Grant the first valid slot searching upward from the RR pointer, wrapping.
  - Set slot_ready for that slot only; pointer <= granted+1 mod NUM_SLOTS.
  - No valid slots: no grant, pointer unchanged.
  - Granted coin value v is added: credit <= credit+v, visible the next cycle. Max credit is PRICE-1+5; it never overflows.
  - If credit+v >= PRICE, the drop is taken on the following IDLE cycle per the rule above. That gives one cycle of credit display.
- Code 00 granted: consumed, credit unchanged, bad_coin=1 the next cycle.
- DROP:
  - drop_req=1, slot_ready=0.
  - On drop_ack=1: drop_count++ and return to IDLE; drop_req falls the next cycle.
  - drop_req is therefore low for at least one cycle between consecutive drops. Example: credit 8 with PRICE 4 gives two separate requests.
- drop_ack while drop_req=0 is ignored.
- Reset mid-handshake: drop_req drops the next cycle, credit is lost, and the pending ack is ignored.
- Simultaneous valid on all slots: exactly one grant per accepting cycle, fair rotation. No slot waits more than NUM_SLOTS accepting cycles.

Optional Feature:
- Macro: VEND_DROP_TIMEOUT_EN.
- Defined:
  - A counter runs while in DROP.
  - If drop_ack is not seen within DROP_TIMEOUT cycles of drop_req rising: abort the drop, credit <= credit+PRICE (refund), drop_fault pulses 1 cycle, return to IDLE.
  - The refunded credit re-triggers a drop on the next IDLE cycle.
  - drop_count is not incremented on timeout.
- Undefined: DROP waits indefinitely; drop_fault is constant 0; no counter logic.

Test Plan:
1. Reset, then slot0 coin 01 four times back to back (valid held) -> slot_ready0 high 4 cycles; credit 1,2,3,4, then 0 with drop_req=1; ack after 3 cycles -> drop_count=1, drop_req low next cycle.
2. slot1 coin 10, then slot1 coin 11 (credit 3+5=8, PRICE 4) -> two drop_req pulses separated by >=1 low cycle, credit 4 then 0, drop_count=2.
3. All 4 slots valid with coin 01 continuously, ack returned immediately -> grants in order 0,1,2,3 then drop, then 0,1,2,3 again; no slot starves.
4. slot2 coin 00 -> consumed, credit stays 0, bad_coin one-cycle pulse; then slot2 coin 11 -> credit 5, drop, credit 1.
5. Assert reset while drop_req=1 -> drop_req, credit and drop_count all 0 next cycle; a late drop_ack has no effect.
6. With VEND_DROP_TIMEOUT_EN and DROP_TIMEOUT=16, credit reaches 4 and no ack is given -> drop_fault pulse 16 cycles after drop_req rises; credit 4 is restored, drop_req re-asserts after one low cycle, drop_count stays 0.
